// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scheduler slice.
// Geometry is fixed to a 640x480 scan scaled down 4x into a 160x120 framebuffer.
package fb_pkg;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;
  localparam int ADDR_W     = 15;
  localparam int FB_SIZE    = FB_W * FB_H;

  localparam int H_TOTAL    = 800;
  localparam int H_VIS      = 640;
  localparam int V_VIS      = 480;
  localparam int V_LAST     = 524;
  // Two cycles ahead: one for the RAM read, one for the pixel register.
  localparam int LOOKAHEAD  = 2;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } color8_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/fb_clear_fsm.sv
// Framebuffer clear sequencer: walks every address once with a latched colour,
// yielding the RAM whenever the display owns the cycle.
module fb_clear_fsm
  import fb_pkg::*;
(
  input  logic              vgaclk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic [7:0]        clear_color,
  input  logic              slot,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [7:0]        clr_data,
  output clr_state_e        state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        color_q, color_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clear_color;
        end
      end
      CLEAR: begin
        // A request arriving mid-clear is deliberately not restarted.
        if (!slot) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  assign clr_we    = (state_q == CLEAR) && !slot;
  assign clr_addr  = cnt_q;
  assign clr_data  = color_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/fb_scheduler.sv
// Single-port framebuffer arbiter: display fetch > clear > graphics writer.
// Optional clear engine is built only when FB_SCHED_CLEAR_EN is defined.
module fb_scheduler
  import fb_pkg::*;
(
  input  logic              vgaclk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [7:0]        wr_data,
  input  logic              clear_req,
  input  logic [7:0]        clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [2:0]        pix_red,
  output logic [2:0]        pix_green,
  output logic [1:0]        pix_blue
);

  // Writer handshake: a transfer occurs on any cycle with wr_valid && wr_ready;
  // wr_ready depends only on the scan position and clear state, never on wr_valid.

  logic [10:0]       la_h_sum;
  logic [9:0]        la_h;
  logic [9:0]        la_v;
  logic              slot;
  logic [ADDR_W-1:0] slot_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic              wr_fire;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        clr_data;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_pend_q, rd_pend_d;
  color8_t           pix_q, pix_d;

  always_comb begin
    la_h_sum = {1'b0, hc} + 11'(LOOKAHEAD);
    la_h     = la_h_sum[9:0];
    la_v     = vc;
    if (la_h_sum >= 11'(H_TOTAL)) begin
      la_h = 10'(la_h_sum - 11'(H_TOTAL));
      la_v = (vc == 10'(V_LAST)) ? 10'd0 : vc + 10'd1;
    end
  end

  assign slot = (la_h < 10'(H_VIS)) && (la_v < 10'(V_VIS)) && (la_h[1:0] == 2'b00);

  assign slot_addr = ADDR_W'(la_v >> SCALE_LOG2) * ADDR_W'(FB_W)
                   + ADDR_W'(la_h >> SCALE_LOG2);

  assign wr_addr     = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

`ifdef FB_SCHED_CLEAR_EN
  clr_state_e clr_state;

  fb_clear_fsm u_clear (
    .vgaclk      (vgaclk),
    .rst         (rst),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .slot        (slot),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .clr_data    (clr_data),
    .state_dbg   (clr_state)
  );

  assign clear_busy = (clr_state == CLEAR);
  assign wr_ready   = !slot && !clear_busy;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_color};
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
  assign clr_data     = '0;
  assign clear_busy   = 1'b0;
  assign wr_ready     = !slot;
`endif

  assign wr_fire = wr_valid && wr_ready;

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (slot) begin
      mem_addr = slot_addr;
    end else if (clr_we) begin
      mem_addr  = clr_addr;
      mem_wdata = clr_data;
      mem_we    = 1'b1;
    end else if (wr_fire) begin
      // Off-screen coordinates complete the handshake but never reach the RAM.
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_we    = wr_in_range;
    end
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  assign addr_d    = mem_addr;
  assign wdata_d   = mem_wdata;
  assign rd_pend_d = slot;
  assign pix_d     = rd_pend_q ? color8_t'(mem_rdata) : pix_q;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_pend_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_pend_q <= rd_pend_d;
      pix_q     <= pix_d;
    end
  end

  assign pix_red   = pix_q.r;
  assign pix_green = pix_q.g;
  assign pix_blue  = pix_q.b;

endmodule

// File: tb/tb_fb_scheduler.sv
// Bench for fb_scheduler: vector table, hand-written corner sequences and a
// randomized scan checked against a screen-position model.
module tb_fb_scheduler;
  import fb_pkg::*;

  logic        vgaclk = 1'b0;
  logic        rst;
  logic [9:0]  hc, vc;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [7:0]  wr_data;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  pix_red, pix_green;
  logic [1:0]  pix_blue;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    int h; int v; bit wv; int x; int y; int d;
    bit e_rdy; bit e_we; bit c_addr; int e_addr; bit c_data; int e_data;
  } vec_t;

  vec_t tbl[15];

  fb_scheduler dut (
    .vgaclk(vgaclk), .rst(rst), .hc(hc), .vc(vc),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Screen position two pixels ahead of the beam, walked as a linear scan index.
  function automatic void model_slot(input int h, input int v, output bit s, output int a);
    int pos, x, y;
    pos = (v * 800 + h + 2) % (800 * 525);
    x = pos % 800;
    y = pos / 800;
    s = (x < 640) && (y < 480) && (x % 4 == 0);
    a = (y / 4) * 160 + (x / 4);
  endfunction

  function automatic int pix_val();
    return int'({pix_red, pix_green, pix_blue});
  endfunction

  task automatic drive(input int h, input int v, input bit wv, input int x, input int y, input int d);
    @(negedge vgaclk);
    hc = 10'(h); vc = 10'(v);
    wr_valid = wv; wr_x = 8'(x); wr_y = 7'(y); wr_data = 8'(d);
    #1;
  endtask

  initial begin
    bit   s;
    int   a, exp_a, sh, sv, n_wr;
    bit   pend, addr_known, exp_we;
    logic [7:0] cur;

    rst = 1'b1; hc = 10'd100; vc = 10'd0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0; mem_rdata = '0;

    // Reset held for two cycles
    repeat (2) @(posedge vgaclk);
    @(negedge vgaclk); #1;
    chk("reset mem_we", mem_we, 0);
    chk("reset pix", pix_val(), 0);
    chk("reset clear_busy", clear_busy, 0);
    rst = 1'b0;

    tbl[0]  = '{700, 10, 1, 5, 3, 'hE3,     1, 1, 1, 485,   1, 'hE3};
    tbl[1]  = '{101, 5, 0, 0, 0, 0,         1, 0, 1, 485,   0, 0};
    tbl[2]  = '{2, 0, 1, 5, 3, 'hE3,        0, 0, 1, 1,     0, 0};
    tbl[3]  = '{3, 0, 1, 6, 3, 'h1C,        1, 1, 1, 486,   1, 'h1C};
    tbl[4]  = '{798, 7, 0, 0, 0, 0,         0, 0, 1, 320,   0, 0};
    tbl[5]  = '{798, 524, 0, 0, 0, 0,       0, 0, 1, 0,     0, 0};
    tbl[6]  = '{100, 10, 1, 200, 3, 'h55,   1, 0, 0, 0,     0, 0};
    tbl[7]  = '{100, 10, 1, 5, 120, 'h55,   1, 0, 0, 0,     0, 0};
    tbl[8]  = '{637, 479, 1, 159, 119, 'hFF, 1, 1, 1, 19199, 1, 'hFF};
    tbl[9]  = '{634, 479, 0, 0, 0, 0,       0, 0, 1, 19199, 0, 0};
    tbl[10] = '{798, 479, 1, 0, 0, 'h42,    1, 1, 1, 0,     1, 'h42};
    tbl[11] = '{638, 100, 1, 159, 0, 'h24,  1, 1, 1, 159,   1, 'h24};
    tbl[12] = '{797, 523, 1, 1, 1, 'h11,    1, 1, 1, 161,   1, 'h11};
    tbl[13] = '{799, 523, 0, 0, 0, 0,       1, 0, 1, 161,   0, 0};
    tbl[14] = '{2, 100, 0, 0, 0, 0,         0, 0, 1, 4001,  0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].wv, tbl[i].x, tbl[i].y, tbl[i].d);
      chk($sformatf("vec%0d wr_ready", i), wr_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("vec%0d clear_busy", i), clear_busy, 0);
      if (tbl[i].c_addr) chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].c_data) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].e_data);
    end

    // Fetch latency across the frame wrap
    drive(798, 524, 0, 0, 0, 0);
    mem_rdata = 8'h00;
    chk("lat read addr", mem_addr, 0);
    drive(799, 524, 0, 0, 0, 0);
    mem_rdata = 8'hE3;
    for (int h = 0; h < 4; h++) begin
      drive(h, 0, 0, 0, 0, 0);
      mem_rdata = 8'h00;
      chk($sformatf("lat pix hc%0d", h), pix_val(), 'hE3);
    end
    drive(4, 0, 0, 0, 0, 0);
    chk("lat pix hc4 next block", pix_val(), 0);

    // Reset landing while a fetch is in flight
    drive(798, 524, 0, 0, 0, 0);
    drive(799, 524, 0, 0, 0, 0);
    mem_rdata = 8'hE3;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst inflight pix hc0", pix_val(), 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rst inflight pix hc1", pix_val(), 0);

    // Randomized continuous scan
    sh = 780; sv = 5; pend = 0; addr_known = 0; exp_a = 0; cur = '0;
    exp_q.delete();
    for (int c = 0; c < 2000; c++) begin
      @(negedge vgaclk);
      hc = 10'(sh); vc = 10'(sv);
      wr_valid = 1'($urandom_range(0, 1));
      wr_x = 8'($urandom_range(0, 170));
      wr_y = 7'($urandom_range(0, 127));
      wr_data = 8'($urandom);
      mem_rdata = 8'($urandom);
`ifndef FB_SCHED_CLEAR_EN
      clear_req = ($urandom_range(0, 31) == 0);
      clear_color = 8'($urandom);
`endif
      #1;
      model_slot(sh, sv, s, a);
      exp_we = !s && wr_valid && (int'(wr_x) < 160) && (int'(wr_y) < 120);
      if (s) exp_a = a;
      else if (wr_valid) exp_a = int'(wr_y) * 160 + int'(wr_x);
      if (s || wr_valid) addr_known = 1;
      chk("rnd wr_ready", wr_ready, !s);
      chk("rnd mem_we", mem_we, exp_we);
      chk("rnd clear_busy", clear_busy, 0);
      if (addr_known) chk("rnd mem_addr", mem_addr, exp_a);
      if (exp_we) chk("rnd mem_wdata", mem_wdata, wr_data);
      if (sh < 640 && sv < 480) begin
        if (sh % 4 == 0) begin
          if (exp_q.size() == 0) chk("rnd pixel queue empty", 0, 1);
          else cur = exp_q.pop_front();
        end
        chk("rnd pix", pix_val(), cur);
      end
      if (pend) exp_q.push_back(mem_rdata);
      pend = s;
      sh++;
      if (sh == 800) begin sh = 0; sv = (sv == 524) ? 0 : sv + 1; end
    end
    clear_req = 1'b0;

`ifdef FB_SCHED_CLEAR_EN
    // Full clear with the writer pushing throughout
    drive(0, 0, 1, 1, 1, 'h77);
    clear_req = 1'b1; clear_color = 8'h5A;
    sh = 1; sv = 0; n_wr = 0;
    drive(sh, sv, 1, 1, 1, 'h77);
    clear_req = 1'b0; clear_color = 8'h00;
    chk("clear busy after req", clear_busy, 1);
    chk("clear wr_ready after req", wr_ready, 0);
    for (int c = 0; c < 40000; c++) begin
      if (c > 0) drive(sh, sv, 1, 1, 1, 'h77);
      if (c == 100) clear_req = 1'b1;
      else clear_req = 1'b0;
      if (!clear_busy) break;
      model_slot(sh, sv, s, a);
      chk("clear wr_ready", wr_ready, 0);
      chk("clear mem_we vs slot", mem_we, !s);
      if (mem_we) begin
        chk("clear addr", mem_addr, n_wr);
        chk("clear data", mem_wdata, 'h5A);
        n_wr++;
      end
      if (c == 39999) chk("clear timeout", 0, 1);
      sh++;
      if (sh == 800) begin sh = 0; sv = (sv == 524) ? 0 : sv + 1; end
    end
    clear_req = 1'b0;
    chk("clear write count", n_wr, 19200);
    chk("clear busy done", clear_busy, 0);
`else
    drive(700, 10, 0, 0, 0, 0);
    clear_req = 1'b1; clear_color = 8'hFF;
    drive(701, 10, 0, 0, 0, 0);
    clear_req = 1'b0;
    chk("noclear busy", clear_busy, 0);
    chk("noclear wr_ready", wr_ready, 1);
    drive(702, 10, 0, 0, 0, 0);
    chk("noclear busy later", clear_busy, 0);
    n_wr = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
